// File: rtl/mux4to1b4_reg_if.sv
// Bus bundle for the 4:1 registered mux. The four data sources, the select and
// the enable arrive on one side; the combinational and registered results leave on the other.
interface mux4to1b4_reg_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       S;
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic [WIDTH-1:0] I2;
  logic [WIDTH-1:0] I3;
  logic [WIDTH-1:0] o_comb;
  logic [WIDTH-1:0] o;
  logic [3:0]       sel_onehot;
  logic [1:0]       sel_q;
  logic             sel_chg;

  modport master (
    output en, S, I0, I1, I2, I3,
    input  o_comb, o, sel_onehot, sel_q, sel_chg
  );

  modport slave (
    input  en, S, I0, I1, I2, I3,
    output o_comb, o, sel_onehot, sel_q, sel_chg
  );
endinterface

// File: rtl/mux4to1b4_reg.sv
// 4:1 WIDTH-bit mux with a combinational path, a one-cycle registered path,
// a one-hot select decode and a registered select-change pulse.

// One bit lane: each output bit is taken only from the same bit of the chosen input.
module mux4to1b4_lane (
  input  logic [1:0] s,
  input  logic [3:0] d,
  output logic       y
);
  always_comb begin
    y = 1'bx;
    case (s)
      2'd0:    y = d[0];
      2'd1:    y = d[1];
      2'd2:    y = d[2];
      2'd3:    y = d[3];
      default: y = 1'bx;
    endcase
  end
endmodule

module mux4to1b4_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  mux4to1b4_reg_if.slave    bus
);
  logic [3:0][WIDTH-1:0] din;
  logic [WIDTH-1:0][3:0] lane_d;
  logic [WIDTH-1:0]      o_comb;
  logic [3:0]            onehot;

  logic [WIDTH-1:0] o_d,   o_q;
  logic [1:0]       sel_d, sel_q;
  logic             chg_d, chg_q;

  assign din = {bus.I3, bus.I2, bus.I1, bus.I0};

  // Transpose input-major to bit-major so each lane sees its four candidate bits.
  always_comb begin
    lane_d = '0;
    for (int b = 0; b < WIDTH; b++)
      for (int k = 0; k < 4; k++)
        lane_d[b][k] = din[k][b];
  end

  genvar gb;
  generate
    for (gb = 0; gb < WIDTH; gb++) begin : g_lane
      mux4to1b4_lane u_lane (
        .s (bus.S),
        .d (lane_d[gb]),
        .y (o_comb[gb])
      );
    end
  endgenerate

  always_comb begin
    onehot = 4'b0000;
    case (bus.S)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = 4'bxxxx;
    endcase
  end

  // The change pulse is cleared on idle edges so it never outlives one cycle.
  always_comb begin
    o_d   = o_q;
    sel_d = sel_q;
    chg_d = 1'b0;
    if (bus.en) begin
      o_d   = o_comb;
      sel_d = bus.S;
      chg_d = (bus.S != sel_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q   <= RESET_VAL;
      sel_q <= 2'd0;
      chg_q <= 1'b0;
    end else begin
      o_q   <= o_d;
      sel_q <= sel_d;
      chg_q <= chg_d;
    end
  end

  assign bus.o_comb     = o_comb;
  assign bus.sel_onehot = onehot;
  assign bus.o          = o_q;
  assign bus.sel_q      = sel_q;
  assign bus.sel_chg    = chg_q;
endmodule

// File: tb/tb_mux4to1b4_reg.sv
// Scoreboard bench for mux4to1b4_reg: directed test-plan sequences followed by
// random traffic, checked against a select-indexed array model.
module tb_mux4to1b4_reg;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux4to1b4_reg_if #(.WIDTH(W)) bus ();

  mux4to1b4_reg #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [W-1:0] y; logic [3:0] oh; } cexp_t;
  typedef struct { logic [W-1:0] o; logic [1:0] sel; logic chg; } rexp_t;

  cexp_t cq[$];
  rexp_t rq[$];
  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_o;
  logic [1:0]   m_sel;
  logic         m_chg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and record what the DUT must show.
  task automatic step(input logic e, input logic [1:0] s,
                      input logic [W-1:0] a, b, c, d, input logic rel);
    logic [W-1:0] dv[4];
    cexp_t ce;
    rexp_t re;
    @(negedge clk);
    bus.en = e; bus.S = s;
    bus.I0 = a; bus.I1 = b; bus.I2 = c; bus.I3 = d;
    if (rel) rst_n = 1'b1;
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
    ce.y  = dv[s];
    ce.oh = 4'b0001 << s;
    cq.push_back(ce);
    if (e) begin
      m_chg = (s != m_sel);
      m_o   = dv[s];
      m_sel = s;
    end else begin
      m_chg = 1'b0;
    end
    re.o = m_o; re.sel = m_sel; re.chg = m_chg;
    rq.push_back(re);
    if (rel) begin
      #1;
      chk("release_o_held", bus.o, '0);
      chk("release_chg_low", bus.sel_chg, 1'b0);
    end
  endtask

  initial begin : comb_mon
    cexp_t ce;
    forever begin
      @(negedge clk);
      #2;
      if (cq.size() != 0) begin
        ce = cq.pop_front();
        chk("o_comb", bus.o_comb, ce.y);
        chk("sel_onehot", bus.sel_onehot, ce.oh);
      end
    end
  end

  initial begin : reg_mon
    rexp_t re;
    forever begin
      @(posedge clk);
      #1;
      if (rq.size() != 0) begin
        re = rq.pop_front();
        chk("o", bus.o, re.o);
        chk("sel_q", bus.sel_q, re.sel);
        chk("sel_chg", bus.sel_chg, re.chg);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    bus.en = 1'b0; bus.S = 2'd0;
    bus.I0 = '0; bus.I1 = '0; bus.I2 = '0; bus.I3 = '0;
    m_o = '0; m_sel = 2'd0; m_chg = 1'b0;
    #1;
    chk("reset_o", bus.o, '0);
    chk("reset_sel_q", bus.sel_q, 2'd0);
    chk("reset_chg", bus.sel_chg, 1'b0);

    // Release between edges with a pending load of I3.
    step(1'b1, 2'd3, 4'd1, 4'd2, 4'd4, 4'd8, 1'b1);

    // Select sweep, each select held two cycles so the pulse drops again.
    for (int s = 0; s < 4; s++) begin
      step(1'b1, s[1:0], 4'd1, 4'd2, 4'd4, 4'd8, 1'b0);
      step(1'b1, s[1:0], 4'd1, 4'd2, 4'd4, 4'd8, 1'b0);
    end

    // Enable hold.
    step(1'b1, 2'd2, 4'd1, 4'd2, 4'd4, 4'd8, 1'b0);
    step(1'b0, 2'd3, 4'd1, 4'd2, 4'd4, 4'd8, 1'b0);
    step(1'b0, 2'd3, 4'd1, 4'd2, 4'd4, 4'd8, 1'b0);
    step(1'b1, 2'd3, 4'd1, 4'd2, 4'd4, 4'd8, 1'b0);
    step(1'b1, 2'd3, 4'd1, 4'd2, 4'd4, 4'd8, 1'b0);

    // Data tracking with constant select.
    step(1'b1, 2'd1, 4'd1, 4'd2, 4'd4, 4'd8, 1'b0);
    step(1'b1, 2'd1, 4'd1, 4'd15, 4'd4, 4'd8, 1'b0);
    step(1'b1, 2'd1, 4'd1, 4'd15, 4'd4, 4'd8, 1'b0);

    // Full-width distinct patterns on every input.
    for (int s = 0; s < 4; s++)
      step(1'b1, s[1:0], 4'd0, 4'd15, 4'd10, 4'd5, 1'b0);

    // Load 8 into o, then assert reset mid-cycle.
    step(1'b1, 2'd3, 4'd1, 4'd2, 4'd4, 4'd8, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_o", bus.o, '0);
    chk("async_reset_sel_q", bus.sel_q, 2'd0);
    chk("async_reset_chg", bus.sel_chg, 1'b0);
    m_o = '0; m_sel = 2'd0; m_chg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held_o", bus.o, '0);
    step(1'b1, 2'd3, 4'd1, 4'd2, 4'd4, 4'd8, 1'b1);
    step(1'b1, 2'd3, 4'd1, 4'd2, 4'd4, 4'd8, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
           W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'b0);

    repeat (3) @(posedge clk);
    #2;
    chk("reg_queue_drained", rq.size(), 0);
    chk("comb_queue_drained", cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mux4to1b4_reg.md
Name: mux4to1b4_reg

Overview:
- 4-input, WIDTH-bit (default 4) multiplexer selected by a 2-bit select S.
- Provides a combinational output and a registered output with one-cycle latency.
- Also provides one-hot select decode and a select-change pulse for downstream datapath steering.
- Sits between four parallel data sources and a single consumer bus.

Parameters:
- WIDTH, 4, bit width of each data input and of the data outputs.
- RESET_VAL, 0, value loaded into the registered output o on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  register load enable for o and sel_q.
- S  input  2  select: 0 picks I0, 1 picks I1, 2 picks I2, 3 picks I3.
- I0  input  WIDTH  data input 0.
- I1  input  WIDTH  data input 1.
- I2  input  WIDTH  data input 2.
- I3  input  WIDTH  data input 3.
- o_comb  output  WIDTH  combinational mux result.
- o  output  WIDTH  registered mux result.
- sel_onehot  output  4  combinational one-hot decode of S (bit k set when S==k).
- sel_q  output  2  registered copy of S as used for o.
- sel_chg  output  1  registered one-cycle pulse when the loaded select differs from the previous sel_q.

Behaviour:
- o_comb:
  - Purely combinational, zero latency.
  - o_comb = I0 when S=0, I1 when S=1, I2 when S=2, I3 when S=3.
  - If S contains X/Z, o_comb drives all-X in simulation. Synthesis must still yield a complete case with no latch.
- sel_onehot: combinational, exactly one bit set for any legal S (S=0 gives 0001, S=3 gives 1000).
- Reset: while rst_n=0, asynchronously and immediately o=RESET_VAL, sel_q=0, sel_chg=0, independent of clk.
- Release: deassertion is sampled on the next rising clk edge. The first load occurs on the first rising edge where rst_n=1 and en=1.
- Rising edge with en=1:
  - o <= o_comb (captures the data inputs and S present before the edge).
  - sel_q <= S.
  - sel_chg <= (S != sel_q).
- Rising edge with en=0:
  - o and sel_q hold.
  - sel_chg <= 0, so it never stays high for more than one cycle unless S changes on every enabled cycle.
- Latency: o and sel_q lag o_comb and S by exactly one enabled clock. The registered path never exhibits combinational feedthrough.
- Data change with constant S: o tracks the new data one enabled cycle later; sel_chg stays 0.
- Simultaneous S and data change before an edge: the register captures the new S with the new data, as one coherent sample.
- Reset mid-operation: outputs return to reset values immediately. There are no pending transactions to recover.
- No width truncation: every output bit of o and o_comb comes from the same-indexed bit of the selected input.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with o previously 8 -> o=0, sel_q=0, sel_chg=0 before the next clk edge.
- Select sweep: I0=1, I1=2, I2=4, I3=8, en=1, S stepped 0,1,2,3 at 50 ns intervals.
  - o_comb = 1, 2, 4, 8 immediately after each step.
  - sel_onehot = 0001, 0010, 0100, 1000.
  - o follows after one clk edge.
  - sel_chg pulses one cycle at each step.
- Enable hold: S=2 loaded (o=4), then en=0, S=3 -> o_comb=8 but o stays 4 and sel_chg=0; then en=1 -> o=8 next edge, sel_chg=1 for one cycle.
- Data tracking: S=1 fixed, I1 changed 2 to 15 -> o_comb=15 at once, o=15 after one edge, sel_chg=0.
- Full-width / all-inputs: I0=0, I1=15, I2=10, I3=5 -> each S value yields the exact 4-bit pattern on o_comb and, one edge later, on o, with no bit crosstalk.
- Reset release: rst_n 0 to 1 between edges with en=1, S=3, I3=8 -> o=0 until the first edge after release, then o=8 and sel_chg=1.
